// File: rtl/ahb_pkg.sv
// Shared AHB codes, arbiter state enum and burst-length helper.
// Imported by ahb_rr_pick and ahb_arbiter.
package ahb_pkg;

  typedef enum logic [1:0] {
    TR_IDLE   = 2'b00,
    TR_BUSY   = 2'b01,
    TR_NONSEQ = 2'b10,
    TR_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    BU_SINGLE = 3'b000,
    BU_INCR   = 3'b001,
    BU_WRAP4  = 3'b010,
    BU_INCR4  = 3'b011,
    BU_WRAP8  = 3'b100,
    BU_INCR8  = 3'b101,
    BU_WRAP16 = 3'b110,
    BU_INCR16 = 3'b111
  } hburst_e;

  typedef enum logic [1:0] {
    RS_OKAY  = 2'b00,
    RS_ERROR = 2'b01,
    RS_RETRY = 2'b10,
    RS_SPLIT = 2'b11
  } hresp_e;

  typedef enum logic [1:0] {
    ST_ARB    = 2'b00,
    ST_BURST  = 2'b01,
    ST_LOCKED = 2'b10
  } arb_state_e;

  function automatic logic [4:0] burst_len(logic [2:0] b);
    case (b)
      3'b010, 3'b011: burst_len = 5'd4;
      3'b100, 3'b101: burst_len = 5'd8;
      3'b110, 3'b111: burst_len = 5'd16;
      default:        burst_len = 5'd1;
    endcase
  endfunction

endpackage

// File: rtl/ahb_rr_pick.sv
// Round-robin picker: first set req bit after 'last', wrapping to 'last'.
// Ports: req (requests), last (current owner) -> winner (index), any.
module ahb_rr_pick
  import ahb_pkg::*;
#(
  parameter int N  = 4,
  parameter int MW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [MW-1:0] last,
  output logic [MW-1:0] winner,
  output logic          any
);

  always_comb begin
    int k;
    logic [MW-1:0] kk;
    k      = 0;
    kk     = '0;
    winner = '0;
    any    = 1'b0;
    for (int i = 1; i <= N; i++) begin
      k  = (int'(last) + i) % N;
      kk = MW'(k);
      if (!any && req[kk]) begin
        any    = 1'b1;
        winner = kk;
      end
    end
  end

endmodule

// File: rtl/ahb_arbiter.sv
// Central AHB arbiter: round-robin grant, burst/lock aware, RETRY/SPLIT rearb.
// Ports: HCLK, HRESETn, HBUSREQ, HLOCK, HTRANS, HBURST, HREADY, HRESP, HSPLIT
//   -> HGRANT, HMASTER, HMASTLOCK. Macro AHB_ARB_SPLIT_EN enables split masking.
module ahb_arbiter
  import ahb_pkg::*;
#(
  parameter int   NUM_MASTERS    = 4,
  parameter int   DEFAULT_MASTER = 0,
  localparam int  MW             = $clog2(NUM_MASTERS)
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  input  logic [NUM_MASTERS-1:0] HBUSREQ,
  input  logic [NUM_MASTERS-1:0] HLOCK,
  input  logic [1:0]             HTRANS,
  input  logic [2:0]             HBURST,
  input  logic                   HREADY,
  input  logic [1:0]             HRESP,
  input  logic [NUM_MASTERS-1:0] HSPLIT,
  output logic [NUM_MASTERS-1:0] HGRANT,
  output logic [MW-1:0]          HMASTER,
  output logic                   HMASTLOCK
);

  localparam logic [MW-1:0] DEF_IDX = MW'(DEFAULT_MASTER);
  localparam logic [NUM_MASTERS-1:0] DEF_GNT =
    NUM_MASTERS'(1) << DEFAULT_MASTER;

  arb_state_e state_q, state_d;
  logic [MW-1:0] gidx_q, gidx_d, pick, win;
  logic [4:0] bl_q, bl_d, bl_nx;
  logic [NUM_MASTERS-1:0] split_mask, elig, grant_d;
  logic any, lock_req, retry, rearb_ok;

  assign elig     = HBUSREQ & ~split_mask;
  assign lock_req = HLOCK[gidx_q] & HBUSREQ[gidx_q];
  // Second cycle of RETRY/SPLIT: both codes have HRESP[1] set.
  assign retry    = HREADY & HRESP[1];

  ahb_rr_pick #(.N(NUM_MASTERS), .MW(MW)) u_pick (
    .req    (elig),
    .last   (gidx_q),
    .winner (pick),
    .any    (any)
  );

  assign win = any ? pick : DEF_IDX;

  always_comb begin
    bl_d = bl_q;
    if (HREADY) begin
      case (HTRANS)
        TR_NONSEQ: bl_d = burst_len(HBURST) - 5'd1;
        TR_SEQ:    bl_d = (bl_q == 5'd0) ? 5'd0 : bl_q - 5'd1;
        default:   bl_d = bl_q;
      endcase
    end
  end

  assign bl_nx    = retry ? 5'd0 : bl_d;
  assign rearb_ok = HREADY & (bl_d <= 5'd1) & ~lock_req;

  always_comb begin
    gidx_d = gidx_q;
    if (rearb_ok || retry) gidx_d = win;
    grant_d = '0;
    grant_d[gidx_d] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    if (retry) begin
      state_d = ST_ARB;
    end else if (HREADY) begin
      if (lock_req) begin
        state_d = ST_LOCKED;
      end else begin
        case (state_q)
          ST_ARB:
            if (HTRANS == TR_NONSEQ && bl_d > 5'd1) state_d = ST_BURST;
          ST_BURST:
            if (bl_d <= 5'd1) state_d = ST_ARB;
          ST_LOCKED:
            if (!HLOCK[gidx_q]) state_d = ST_ARB;
          default:
            state_d = ST_ARB;
        endcase
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q   <= ST_ARB;
      gidx_q    <= DEF_IDX;
      bl_q      <= 5'd0;
      HGRANT    <= DEF_GNT;
      HMASTER   <= DEF_IDX;
      HMASTLOCK <= 1'b0;
    end else if (HREADY) begin
      state_q   <= state_d;
      gidx_q    <= gidx_d;
      bl_q      <= bl_nx;
      HGRANT    <= grant_d;
      HMASTER   <= gidx_q;
      HMASTLOCK <= HLOCK[gidx_q];
    end
  end

`ifdef AHB_ARB_SPLIT_EN
  logic [NUM_MASTERS-1:0] split_set;

  always_comb begin
    split_set = '0;
    if (HREADY && HRESP == RS_SPLIT) split_set[gidx_q] = 1'b1;
  end

  // Resume clear wins over a same-edge set.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) split_mask <= '0;
    else          split_mask <= (split_mask | split_set) & ~HSPLIT;
  end
`else
  logic unused_split;
  assign split_mask   = '0;
  assign unused_split = ^{HSPLIT, HRESP[0]};
`endif

endmodule

// File: tb/tb_ahb_arbiter.sv
// Self-checking bench for ahb_arbiter: vector table + expected-output queue.
// Covers round robin, bursts, lock, wait states, RETRY/SPLIT, async reset.
module tb_ahb_arbiter;
  import ahb_pkg::*;

  localparam int N = 4;

  logic         HCLK = 1'b0;
  logic         HRESETn = 1'b0;
  logic [N-1:0] HBUSREQ = '0, HLOCK = '0, HSPLIT = '0;
  logic [1:0]   HTRANS = 2'b00, HRESP = 2'b00;
  logic [2:0]   HBURST = 3'b000;
  logic         HREADY = 1'b1;
  logic [N-1:0] HGRANT;
  logic [1:0]   HMASTER;
  logic         HMASTLOCK;

  always #5 HCLK = ~HCLK;

  ahb_arbiter #(.NUM_MASTERS(N), .DEFAULT_MASTER(0)) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .HBUSREQ   (HBUSREQ),
    .HLOCK     (HLOCK),
    .HTRANS    (HTRANS),
    .HBURST    (HBURST),
    .HREADY    (HREADY),
    .HRESP     (HRESP),
    .HSPLIT    (HSPLIT),
    .HGRANT    (HGRANT),
    .HMASTER   (HMASTER),
    .HMASTLOCK (HMASTLOCK)
  );

  typedef struct {
    logic [3:0] br;
    logic [3:0] lk;
    logic [1:0] tr;
    logic [2:0] bu;
    logic       rd;
    logic [1:0] rs;
    logic [3:0] sp;
    logic [3:0] eg;
    logic [1:0] em;
    logic       el;
  } vec_t;

  typedef struct {
    logic [3:0] g;
    logic [1:0] m;
    logic       l;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int total = 0;
  int bad = 0;

  function automatic vec_t v(logic [3:0] br, logic [3:0] lk, logic [1:0] tr,
                             logic [2:0] bu, logic rd, logic [1:0] rs,
                             logic [3:0] sp, logic [3:0] eg, logic [1:0] em,
                             logic el);
    vec_t r;
    r.br = br; r.lk = lk; r.tr = tr; r.bu = bu; r.rd = rd;
    r.rs = rs; r.sp = sp; r.eg = eg; r.em = em; r.el = el;
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic apply(vec_t x, string tag);
    exp_t e;
    HBUSREQ = x.br; HLOCK = x.lk; HTRANS = x.tr; HBURST = x.bu;
    HREADY = x.rd; HRESP = x.rs; HSPLIT = x.sp;
    e.g = x.eg; e.m = x.em; e.l = x.el;
    sb.push_back(e);
    @(posedge HCLK);
    #1;
    if (sb.size() == 0) begin
      total++; bad++;
      $display("FAIL %s.sb: got empty want entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, ".grant"}, 32'(HGRANT), 32'(e.g));
      chk({tag, ".master"}, 32'(HMASTER), 32'(e.m));
      chk({tag, ".mlock"}, 32'(HMASTLOCK), 32'(e.l));
    end
  endtask

  localparam logic [1:0] I = TR_IDLE, NS = TR_NONSEQ, S = TR_SEQ;
  localparam logic [2:0] SG = BU_SINGLE, I4 = BU_INCR4;
  localparam logic [2:0] I8 = BU_INCR8, I16 = BU_INCR16;
  localparam logic [1:0] OK = RS_OKAY, ER = RS_ERROR, SP = RS_SPLIT;

  initial begin
    // round robin singles between M1 and M2
    tbl.push_back(v(4'b0110, 0, NS, SG, 1, OK, 0, 4'b0010, 0, 0));
    tbl.push_back(v(4'b0110, 0, NS, SG, 1, OK, 0, 4'b0100, 1, 0));
    tbl.push_back(v(4'b0110, 0, NS, SG, 1, OK, 0, 4'b0010, 2, 0));
    tbl.push_back(v(4'b0110, 0, NS, SG, 1, OK, 0, 4'b0100, 1, 0));
    // M1 INCR4 with M2 waiting
    tbl.push_back(v(4'b0010, 0, I,  SG, 1, OK, 0, 4'b0010, 2, 0));
    tbl.push_back(v(4'b0110, 0, NS, I4, 1, OK, 0, 4'b0010, 1, 0));
    tbl.push_back(v(4'b0110, 0, S,  I4, 1, OK, 0, 4'b0010, 1, 0));
    tbl.push_back(v(4'b0110, 0, S,  I4, 1, OK, 0, 4'b0100, 1, 0));
    tbl.push_back(v(4'b0100, 0, S,  I4, 1, OK, 0, 4'b0100, 2, 0));
    tbl.push_back(v(4'b0100, 0, NS, SG, 1, OK, 0, 4'b0100, 2, 0));
    // M2 INCR8, wait states with changing requests, ERROR mid-burst
    tbl.push_back(v(4'b0101, 0, NS, I8, 1, OK, 0, 4'b0100, 2, 0));
    tbl.push_back(v(4'b0101, 0, S,  I8, 1, OK, 0, 4'b0100, 2, 0));
    tbl.push_back(v(4'b1011, 0, S,  I8, 0, OK, 0, 4'b0100, 2, 0));
    tbl.push_back(v(4'b0001, 0, S,  I8, 0, OK, 0, 4'b0100, 2, 0));
    tbl.push_back(v(4'b1111, 0, S,  I8, 0, OK, 0, 4'b0100, 2, 0));
    tbl.push_back(v(4'b0101, 0, S,  I8, 1, OK, 0, 4'b0100, 2, 0));
    tbl.push_back(v(4'b0101, 0, S,  I8, 1, OK, 0, 4'b0100, 2, 0));
    tbl.push_back(v(4'b0101, 0, S,  I8, 1, ER, 0, 4'b0100, 2, 0));
    tbl.push_back(v(4'b0101, 0, S,  I8, 1, OK, 0, 4'b0100, 2, 0));
    tbl.push_back(v(4'b0101, 0, S,  I8, 1, OK, 0, 4'b0001, 2, 0));
    tbl.push_back(v(4'b0001, 0, S,  I8, 1, OK, 0, 4'b0001, 0, 0));
    // M3 locked sequence against M0
    tbl.push_back(v(4'b1001, 4'b1000, NS, SG, 1, OK, 0, 4'b1000, 0, 0));
    for (int i = 0; i < 6; i++)
      tbl.push_back(v(4'b1001, 4'b1000, NS, SG, 1, OK, 0, 4'b1000, 3, 1));
    tbl.push_back(v(4'b1001, 4'b0000, NS, SG, 1, OK, 0, 4'b0001, 3, 0));
    tbl.push_back(v(4'b0000, 4'b0000, I,  SG, 1, OK, 0, 4'b0001, 0, 0));
    // SPLIT mid-burst for M2
    tbl.push_back(v(4'b0100, 0, I,  SG,  1, OK, 0, 4'b0100, 0, 0));
    tbl.push_back(v(4'b0110, 0, NS, I16, 1, OK, 0, 4'b0100, 2, 0));
    tbl.push_back(v(4'b0110, 0, S,  I16, 1, OK, 0, 4'b0100, 2, 0));
    tbl.push_back(v(4'b0110, 0, S,  I16, 0, SP, 0, 4'b0100, 2, 0));
    tbl.push_back(v(4'b0110, 0, I,  I16, 1, SP, 0, 4'b0010, 2, 0));
`ifdef AHB_ARB_SPLIT_EN
    tbl.push_back(v(4'b0110, 0, NS, SG, 1, OK, 0, 4'b0010, 1, 0));
    tbl.push_back(v(4'b0110, 0, NS, SG, 1, OK, 4'b0100, 4'b0010, 1, 0));
`else
    tbl.push_back(v(4'b0110, 0, NS, SG, 1, OK, 0, 4'b0100, 1, 0));
    tbl.push_back(v(4'b0110, 0, NS, SG, 1, OK, 4'b0100, 4'b0010, 2, 0));
`endif
    tbl.push_back(v(4'b0110, 0, NS, SG, 1, OK, 0, 4'b0100, 1, 0));
    // burst started just before an async reset
    tbl.push_back(v(4'b0100, 0, NS, I8, 1, OK, 0, 4'b0100, 2, 0));

    HRESETn = 1'b0;
    repeat (2) @(posedge HCLK);
    #1;
    chk("rst.grant", 32'(HGRANT), 32'h1);
    chk("rst.master", 32'(HMASTER), 32'h0);
    chk("rst.mlock", 32'(HMASTLOCK), 32'h0);
    HRESETn = 1'b1;

    for (int i = 0; i < tbl.size(); i++)
      apply(tbl[i], $sformatf("v%0d", i));

    // async reset mid-burst, well away from a clock edge
    #2;
    HRESETn = 1'b0;
    #1;
    chk("arst.grant", 32'(HGRANT), 32'h1);
    chk("arst.master", 32'(HMASTER), 32'h0);
    chk("arst.mlock", 32'(HMASTLOCK), 32'h0);
    @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    // burst counter must have cleared: IDLE with M1 requesting rearbs at once
    apply(v(4'b0010, 0, I, SG, 1, OK, 0, 4'b0010, 0, 0), "post_rst0");
    apply(v(4'b0000, 0, I, SG, 1, OK, 0, 4'b0001, 1, 0), "post_rst1");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ahb_arbiter.md
# ahb_arbiter

Central AHB arbiter for the system bus. It takes bus requests (`HBUSREQ`) and lock requests (`HLOCK`) from up to `NUM_MASTERS` AHB master ports and returns one-hot `HGRANT`. It drives `HMASTER` and `HMASTLOCK` to the address/data muxes and slaves. Arbitration is round-robin and never breaks a fixed-length burst or a locked sequence. RETRY and SPLIT responses re-open arbitration.

## Interface
- `NUM_MASTERS`, 4: number of masters; legal range 2..16.
- `DEFAULT_MASTER`, 0: master granted when nobody requests.
- `MW`, `$clog2(NUM_MASTERS)`: `HMASTER` width (derived, not overridable).

Ports (name, direction, width, meaning):
- `HCLK` in 1: bus clock.
- `HRESETn` in 1: reset, asynchronous, active-low.
- `HBUSREQ` in `NUM_MASTERS`: per-master bus request.
- `HLOCK` in `NUM_MASTERS`: per-master locked-transfer request.
- `HTRANS` in 2: muxed transfer type of the current address owner.
- `HBURST` in 3: muxed burst type of the current address owner.
- `HREADY` in 1: muxed slave ready.
- `HRESP` in 2: muxed slave response.
- `HSPLIT` in `NUM_MASTERS`: OR of slave split-resume vectors (used only with the macro).
- `HGRANT` out `NUM_MASTERS`: one-hot grant, registered.
- `HMASTER` out `MW`: index of the current address-phase owner, registered.
- `HMASTLOCK` out 1: current address-phase transfer is locked, registered.

## Operation
- Grant state `gidx` (index). `HGRANT` = onehot(`gidx`).
- Eligible requesters: `HBUSREQ & ~split_mask`.
- Winner: the first eligible index searching `gidx+1`, `gidx+2`, … modulo `NUM_MASTERS`, wrapping back to `gidx` last. With no eligible requester the winner is `DEFAULT_MASTER`.
- Beat counter `burst_left` (5 bits) tracks the owner's remaining address beats. It updates on edges where `HREADY`=1:
  - NONSEQ: load len-1. len = 4/8/16 for WRAP4/INCR4, WRAP8/INCR8, WRAP16/INCR16, else 1.
  - SEQ: decrement, saturating at 0.
  - IDLE/BUSY: hold.
- `rearb_ok` = `HREADY` & (`burst_left_next` ≤ 1) & ~(`HLOCK[gidx]` & `HBUSREQ[gidx]`).
- The FSM updates its state and `gidx` only on edges where `HREADY`=1.
- FSM states:
  - ARB: no burst or lock in progress.
  - BURST: `burst_left_next` > 1.
  - LOCKED: the granted master holds `HLOCK`.
- FSM transitions:
  - ARB→BURST on an accepted NONSEQ with len > 2.
  - BURST→ARB when `burst_left_next` ≤ 1.
  - Any→LOCKED when `HLOCK[gidx]` & `HBUSREQ[gidx]`.
  - LOCKED→ARB the first edge `HLOCK[gidx]`=0.
  - `gidx` ← winner only when `rearb_ok`.
- RETRY/SPLIT: on the second response cycle (`HREADY`=1, `HRESP`=10 or 11), `burst_left`←0, state←ARB, `gidx`←winner. The RETRY master stays eligible.
- ERROR (01): no effect on arbitration. The burst counter continues.
- `HMASTER` ← `gidx` on every edge with `HREADY`=1, so it lags `HGRANT` by one accepted address.
- `HMASTLOCK` ← `HLOCK[gidx]` on the same edges.
- A single master requesting continuously keeps the grant (re-grant to self).

## Timing
- Reset values:
  - `HGRANT` = onehot(`DEFAULT_MASTER`), `HMASTER` = `DEFAULT_MASTER`, `HMASTLOCK` = 0.
  - State = ARB, `burst_left` = 0, `split_mask` = 0.
- Request-to-grant latency: 1 `HCLK` edge when `rearb_ok`. `HGRANT` changes at the first `HREADY`=1 edge after `HBUSREQ` is sampled.
- Grant-to-ownership: `HMASTER` switches at the next `HREADY`=1 edge after `HGRANT` changes.
- `HREADY`=0 freezes every register except `split_mask` set/clear.
- Fixed 4-beat burst: rearbitration occurs at the edge accepting beat 3, so the new owner's NONSEQ follows beat 4 with no dead cycle.
- Reset asserted mid-burst: all registers return to reset values immediately (asynchronous).

## Configuration
- `AHB_ARB_SPLIT_EN` defined:
  - `split_mask[gidx]` is set on the SPLIT second cycle.
  - `split_mask[i]` is cleared at any edge where `HSPLIT[i]`=1. Clear takes priority over set for the same bit.
  - Masked masters are ineligible.
  - If every requester is masked, grant goes to `DEFAULT_MASTER`.
- Not defined:
  - `split_mask` is tied to 0 and `HSPLIT` is ignored.
  - SPLIT is treated as RETRY.

## Structure
- Package `ahb_pkg` holds:
  - `HTRANS` codes: IDLE, BUSY, NONSEQ, SEQ.
  - `HBURST` codes.
  - `HRESP` codes: OKAY, ERROR, RETRY, SPLIT.
  - The arbiter state enum.
  - The burst-length function.
- Sub-module `ahb_rr_pick`: combinational round-robin priority picker.
  - Inputs: `req`, `last`.
  - Outputs: `winner`, `any`.
  - Instantiated once.

## Test plan
- Reset with `NUM_MASTERS`=4, no requests → `HGRANT`=4'b0001, `HMASTER`=0, `HMASTLOCK`=0.
- `HBUSREQ`=4'b0110, `HREADY`=1, SINGLE NONSEQ each cycle → `HGRANT` alternates 0010, 0100, 0010; `HMASTER` follows one edge later.
- M1 issues INCR4 while M2 requests → `HGRANT` stays 0010 through beat 2 and changes to 0100 at the beat-3 edge; M2's NONSEQ follows beat 4.
- M3 asserts `HLOCK`+`HBUSREQ` with M0 requesting → grant held 1000 for 6 cycles, `HMASTLOCK`=1; after `HLOCK` drops, `HGRANT`=0001.
- `HREADY`=0 for 3 cycles mid-burst with `HBUSREQ` changing → `HGRANT`, `HMASTER` and `burst_left` are unchanged.
- With `AHB_ARB_SPLIT_EN`, SPLIT to M2 → M2 is masked and the grant goes to M1. `HSPLIT`=4'b0100 for one cycle → M2 becomes eligible and is granted next round.
